// File: rtl/sb_injector_pkg.sv
// Shared router definitions for the side-buffer injection stage.
//   FLIT_W     : flit width in bits
//   EMPTY_FLIT : encoding of an empty slot / empty side-buffer offer
//   slot_e     : slot index constants, east has highest injection priority
package sb_injector_pkg;

  localparam int unsigned FLIT_W = 11;
  localparam logic [FLIT_W-1:0] EMPTY_FLIT = '0;
  localparam int unsigned NUM_SLOTS = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    SLOT_E = 2'd0,
    SLOT_W = 2'd1,
    SLOT_N = 2'd2,
    SLOT_S = 2'd3
  } slot_e;

endpackage

// File: rtl/sb_slot_select.sv
// Injection target selector.
//   empty  : per-slot empty mask, bit index = slot index (E=0, W=1, N=2, S=3)
//   target : one-hot first empty slot, priority E > W > N > S; '0 if none
//   found  : at least one slot is empty
module sb_slot_select
  import sb_injector_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] empty,
  output logic [NUM_SLOTS-1:0] target,
  output logic                 found
);

  // Lowest set bit of the mask is the highest-priority empty slot.
  always_comb begin
    target = empty & (~empty + 4'd1);
    found  = |empty;
  end

endmodule

// File: rtl/sb_injector.sv
// Side-buffer injection stage of a bufferless deflection router.
// Places the side-buffer flit into the highest-priority empty slot and
// registers the four slots plus the pop indication (1 cycle latency).
//   clk, rst           : clock, asynchronous active-high reset
//   eastad..southad    : slot 0..3 input flits (11'h000 = empty)
//   sbinject           : flit offered by the side buffer (11'h000 = none)
//   ead, wad, nad, sad : registered slot 0..3 results
//   sbtaken            : registered; side-buffer flit was injected
module sb_injector
  import sb_injector_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] eastad,
  input  logic [FLIT_W-1:0] westad,
  input  logic [FLIT_W-1:0] northad,
  input  logic [FLIT_W-1:0] southad,
  input  logic [FLIT_W-1:0] sbinject,
  output logic [FLIT_W-1:0] ead,
  output logic [FLIT_W-1:0] wad,
  output logic [FLIT_W-1:0] nad,
  output logic [FLIT_W-1:0] sad,
  output logic              sbtaken
);

  flit_t                slot_in   [NUM_SLOTS];
  flit_t                slot_next [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] empty_mask;
  logic [NUM_SLOTS-1:0] target;
  logic                 found;
  logic                 inject;

  always_comb begin
    slot_in[SLOT_E] = eastad;
    slot_in[SLOT_W] = westad;
    slot_in[SLOT_N] = northad;
    slot_in[SLOT_S] = southad;
  end

  always_comb begin
    empty_mask = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      empty_mask[i] = (slot_in[i] == EMPTY_FLIT);
    end
  end

  sb_slot_select u_sel (
    .empty  (empty_mask),
    .target (target),
    .found  (found)
  );

  assign inject = found && (sbinject != EMPTY_FLIT);

  // Non-target empty slots already carry EMPTY_FLIT, so plain pass-through
  // covers them without a separate clear path.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      slot_next[i] = (inject && target[i]) ? sbinject : slot_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ead     <= '0;
      wad     <= '0;
      nad     <= '0;
      sad     <= '0;
      sbtaken <= 1'b0;
    end else begin
      ead     <= slot_next[SLOT_E];
      wad     <= slot_next[SLOT_W];
      nad     <= slot_next[SLOT_N];
      sad     <= slot_next[SLOT_S];
      sbtaken <= inject;
    end
  end

endmodule

// File: tb/tb_sb_injector.sv
module tb_sb_injector;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] eastad, westad, northad, southad, sbinject;
  logic [10:0] ead, wad, nad, sad;
  logic        sbtaken;

  int checks = 0;
  int errors = 0;

  sb_injector dut (
    .clk      (clk),
    .rst      (rst),
    .eastad   (eastad),
    .westad   (westad),
    .northad  (northad),
    .southad  (southad),
    .sbinject (sbinject),
    .ead      (ead),
    .wad      (wad),
    .nad      (nad),
    .sad      (sad),
    .sbtaken  (sbtaken)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [10:0] e, w, n, s, sb;
    logic [10:0] xe, xw, xn, xs;
    logic        xt;
  } vec_t;

  vec_t vecs [5];

  // Packed result: {ead, wad, nad, sad, sbtaken}
  function automatic logic [44:0] outs();
    return {ead, wad, nad, sad, sbtaken};
  endfunction

  // Reference: slots pass through; a non-empty offer fills the first
  // empty slot scanning E, W, N, S.
  function automatic logic [44:0] model(input logic [10:0] e, w, n, s, sb);
    logic [10:0] slot [4];
    logic        taken;
    slot[0] = e; slot[1] = w; slot[2] = n; slot[3] = s;
    taken = 1'b0;
    if (sb != 11'd0) begin
      for (int i = 0; i < 4; i++) begin
        if (!taken && slot[i] == 11'd0) begin
          slot[i] = sb;
          taken = 1'b1;
        end
      end
    end
    return {slot[0], slot[1], slot[2], slot[3], taken};
  endfunction

  task automatic check(input string name, input logic [44:0] exp);
    logic [44:0] act;
    act = outs();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got e=%h w=%h n=%h s=%h taken=%b, expected e=%h w=%h n=%h s=%h taken=%b",
               name, act[44:34], act[33:23], act[22:12], act[11:1], act[0],
               exp[44:34], exp[33:23], exp[22:12], exp[11:1], exp[0]);
    end
  endtask

  task automatic drive(input logic [10:0] e, w, n, s, sb);
    eastad = e; westad = w; northad = n; southad = s; sbinject = sb;
  endtask

  initial begin
    vecs[0] = '{"west_inject", 11'b00000101100, 11'd0, 11'd0, 11'd0, 11'b00000100000,
                11'b00000101100, 11'b00000100000, 11'd0, 11'd0, 1'b1};
    vecs[1] = '{"north_inject", 11'b10000100001, 11'b00000100111, 11'd0, 11'b00000000101, 11'b00000111111,
                11'b10000100001, 11'b00000100111, 11'b00000111111, 11'b00000000101, 1'b1};
    vecs[2] = '{"all_full", 11'h00C, 11'h015, 11'h03C, 11'h003, 11'h00C,
                11'h00C, 11'h015, 11'h03C, 11'h003, 1'b0};
    vecs[3] = '{"sb_empty", 11'd0, 11'h027, 11'h008, 11'h034, 11'd0,
                11'd0, 11'h027, 11'h008, 11'h034, 1'b0};
    vecs[4] = '{"all_empty", 11'd0, 11'd0, 11'd0, 11'd0, 11'h7FF,
                11'h7FF, 11'd0, 11'd0, 11'd0, 1'b1};

    // Reset with all inputs non-empty: outputs clear before any clock edge.
    rst = 1'b1;
    drive(11'h7FF, 11'h123, 11'h456, 11'h001, 11'h3AA);
    #1 check("reset_async", '0);
    @(posedge clk); #1 check("reset_held", '0);

    // First post-reset result: 1 cycle after first edge with rst low.
    @(negedge clk);
    rst = 1'b0;
    drive(11'd0, 11'h011, 11'd0, 11'h022, 11'h033);
    @(posedge clk); #1 check("first_after_reset", {11'h033, 11'h011, 11'd0, 11'h022, 1'b1});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].e, vecs[i].w, vecs[i].n, vecs[i].s, vecs[i].sb);
      @(posedge clk); #1;
      check(vecs[i].name, {vecs[i].xe, vecs[i].xw, vecs[i].xn, vecs[i].xs, vecs[i].xt});
    end

    // Back-to-back: east empty, then south empty, inputs change every cycle.
    @(negedge clk);
    drive(11'd0, 11'h001, 11'h002, 11'h003, 11'h055);
    @(posedge clk); #1;
    check("b2b_east", {11'h055, 11'h001, 11'h002, 11'h003, 1'b1});
    drive(11'h004, 11'h005, 11'h006, 11'd0, 11'h066);
    @(posedge clk); #1;
    check("b2b_south", {11'h004, 11'h005, 11'h006, 11'h066, 1'b1});
    drive(11'h00A, 11'd0, 11'd0, 11'd0, 11'h077);
    @(posedge clk); #1;
    check("b2b_one_inject", {11'h00A, 11'h077, 11'd0, 11'd0, 1'b1});

    // Mid-operation asynchronous reset.
    #2 rst = 1'b1;
    #1 check("reset_mid_op", '0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic at full throughput against the reference model.
    for (int k = 0; k < 400; k++) begin
      logic [10:0] r [5];
      logic [44:0] exp;
      for (int j = 0; j < 5; j++) begin
        r[j] = ($urandom_range(0, 2) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      end
      drive(r[0], r[1], r[2], r[3], r[4]);
      exp = model(r[0], r[1], r[2], r[3], r[4]);
      @(posedge clk); #1;
      check("random", exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
